// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for a MonPro Montgomery datapath.
// Holds the exponent and control state; issues one MonPro op at a time.
module modexp_ctrl #(
  parameter  int DATA_WIDTH = 64,
  parameter  int NUM_WORDS  = 16,
  localparam int KEY_BITS   = DATA_WIDTH * NUM_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  e_valid,
  input  logic [DATA_WIDTH-1:0] e_word,
  output logic                  e_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  mp_start,
  output logic [1:0]            mp_a_sel,
  output logic [1:0]            mp_b_sel,
  output logic                  mp_dst_sel,
  input  logic                  mp_done,
  output logic [3:0]            state,
  output logic [9:0]            bit_idx,
  output logic [11:0]           op_count
);

  localparam int WCW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_PRE_M = 4'd2,
    S_PRE_X = 4'd3,
    S_SCAN  = 4'd4,
    S_SQR   = 4'd5,
    S_MUL   = 4'd6,
    S_NEXT  = 4'd7,
    S_POST  = 4'd8,
    S_DONE  = 4'd9
  } state_t;

  // Operand select codes as seen by the datapath muxes.
  localparam logic [1:0] A_X = 2'd0, A_MBAR = 2'd1, A_M  = 2'd2, A_ONE = 2'd3;
  localparam logic [1:0] B_X = 2'd0, B_R2   = 2'd2, B_ONE = 2'd3;
  localparam logic       D_X = 1'b0, D_MBAR = 1'b1;

  state_t                state_q, state_d;
  logic [KEY_BITS-1:0]   e_q, e_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [9:0]            bit_idx_q, bit_idx_d;
  logic [11:0]           op_count_q, op_count_d;
  logic                  e_ready_q, e_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mp_start_q, mp_start_d;
  logic [1:0]            a_sel_q, a_sel_d;
  logic [1:0]            b_sel_q, b_sel_d;
  logic                  dst_sel_q, dst_sel_d;
  logic                  mp_ack;
  logic                  entering_op;

  function automatic logic is_op(input state_t s);
    return (s == S_PRE_M) || (s == S_PRE_X) || (s == S_SQR) ||
           (s == S_MUL)   || (s == S_POST);
  endfunction

  // A completion arriving in the launch cycle belongs to no op of ours.
  assign mp_ack = mp_done && !mp_start_q;

  always_comb begin
    state_d     = state_q;
    e_d         = e_q;
    word_cnt_d  = word_cnt_q;
    bit_idx_d   = bit_idx_q;
    op_count_d  = op_count_q;
    a_sel_d     = a_sel_q;
    b_sel_d     = b_sel_q;
    dst_sel_d   = dst_sel_q;
    entering_op = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          op_count_d = '0;
          word_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (e_valid && e_ready_q) begin
          e_d[DATA_WIDTH*word_cnt_q +: DATA_WIDTH] = e_word;
          if (word_cnt_q == WCW'(NUM_WORDS - 1)) begin
            state_d    = S_PRE_M;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
      end
      S_PRE_M: if (mp_ack) state_d = S_PRE_X;
      S_PRE_X: begin
        if (mp_ack) begin
          state_d   = S_SCAN;
          bit_idx_d = 10'(KEY_BITS - 1);
        end
      end
      S_SCAN: begin
        if (e_q[bit_idx_q])          state_d = S_SQR;
        else if (bit_idx_q == '0)    state_d = S_POST;
        else                         bit_idx_d = bit_idx_q - 10'd1;
      end
      S_SQR:   if (mp_ack) state_d = e_q[bit_idx_q] ? S_MUL : S_NEXT;
      S_MUL:   if (mp_ack) state_d = S_NEXT;
      S_NEXT: begin
        if (bit_idx_q == '0) begin
          state_d = S_POST;
        end else begin
          state_d   = S_SQR;
          bit_idx_d = bit_idx_q - 10'd1;
        end
      end
      S_POST:  if (mp_ack) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Launch, count and latch selects on the first cycle of each op state.
    entering_op = is_op(state_d) && (state_d != state_q);
    if (entering_op) begin
      op_count_d = op_count_q + 12'd1;
      case (state_d)
        S_PRE_M: begin a_sel_d = A_M;    b_sel_d = B_R2;  dst_sel_d = D_MBAR; end
        S_PRE_X: begin a_sel_d = A_ONE;  b_sel_d = B_R2;  dst_sel_d = D_X;    end
        S_SQR:   begin a_sel_d = A_X;    b_sel_d = B_X;   dst_sel_d = D_X;    end
        S_MUL:   begin a_sel_d = A_MBAR; b_sel_d = B_X;   dst_sel_d = D_X;    end
        S_POST:  begin a_sel_d = A_X;    b_sel_d = B_ONE; dst_sel_d = D_X;    end
        default: begin a_sel_d = a_sel_q; b_sel_d = b_sel_q; dst_sel_d = dst_sel_q; end
      endcase
    end

    mp_start_d = entering_op;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    e_ready_d  = (state_d == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      e_q        <= '0;
      word_cnt_q <= '0;
      bit_idx_q  <= '0;
      op_count_q <= '0;
      e_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mp_start_q <= 1'b0;
      a_sel_q    <= '0;
      b_sel_q    <= '0;
      dst_sel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      e_q        <= e_d;
      word_cnt_q <= word_cnt_d;
      bit_idx_q  <= bit_idx_d;
      op_count_q <= op_count_d;
      e_ready_q  <= e_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mp_start_q <= mp_start_d;
      a_sel_q    <= a_sel_d;
      b_sel_q    <= b_sel_d;
      dst_sel_q  <= dst_sel_d;
    end
  end

  assign e_ready    = e_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign mp_start   = mp_start_q;
  assign mp_a_sel   = a_sel_q;
  assign mp_b_sel   = b_sel_q;
  assign mp_dst_sel = dst_sel_q;
  assign state      = state_q;
  assign bit_idx    = bit_idx_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Randomized bench for modexp_ctrl: a MonPro responder plus a square-and-multiply
// reference model that predicts the op stream, op count and SCAN length.
module tb_modexp_ctrl;

  localparam int DW = 64;
  localparam int NW = 16;
  localparam int KB = DW * NW;

  // Op encodings {a_sel, b_sel, dst_sel}
  localparam logic [4:0] OP_PRE_M = {2'd2, 2'd2, 1'b1};
  localparam logic [4:0] OP_PRE_X = {2'd3, 2'd2, 1'b0};
  localparam logic [4:0] OP_SQR   = {2'd0, 2'd0, 1'b0};
  localparam logic [4:0] OP_MUL   = {2'd1, 2'd0, 1'b0};
  localparam logic [4:0] OP_POST  = {2'd0, 2'd3, 1'b0};

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          e_valid;
  logic [DW-1:0] e_word;
  logic          e_ready;
  logic          busy;
  logic          done;
  logic          mp_start;
  logic [1:0]    mp_a_sel;
  logic [1:0]    mp_b_sel;
  logic          mp_dst_sel;
  logic          mp_done;
  logic [3:0]    state;
  logic [9:0]    bit_idx;
  logic [11:0]   op_count;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [4:0] expOps[$];
  logic [4:0] actOps[$];
  int         expOpCount;
  int         expScan;

  always #5 clk = ~clk;

  modexp_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .e_valid    (e_valid),
    .e_word     (e_word),
    .e_ready    (e_ready),
    .busy       (busy),
    .done       (done),
    .mp_start   (mp_start),
    .mp_a_sel   (mp_a_sel),
    .mp_b_sel   (mp_b_sel),
    .mp_dst_sel (mp_dst_sel),
    .mp_done    (mp_done),
    .state      (state),
    .bit_idx    (bit_idx),
    .op_count   (op_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: square-and-multiply from the top set bit down, framed by setup/post ops.
  task automatic buildModel(input logic [KB-1:0] e);
    int h = -1;
    int p = 0;
    expOps.delete();
    for (int i = 0; i < KB; i++) begin
      if (e[i]) begin
        h = i;
        p++;
      end
    end
    expOps.push_back(OP_PRE_M);
    expOps.push_back(OP_PRE_X);
    for (int i = h; i >= 0; i--) begin
      expOps.push_back(OP_SQR);
      if (e[i]) expOps.push_back(OP_MUL);
    end
    expOps.push_back(OP_POST);
    expOpCount = 3 + (h + 1) + p;
    expScan    = (h < 0) ? KB : KB - h;
  endtask

  task automatic applyStimulus(input logic [KB-1:0] e, input int dMin, input int dMax,
                               input bit abuse, input bit abortInSqr, input string name);
    int  wordsSent = 0;
    int  cyc = 0;
    int  cnt = 0;
    int  scanCycles = 0;
    int  doneSeen = 0;
    int  selBad = 0;
    int  extraStart = 0;
    int  busyDrop = 0;
    int  opBad = 0;
    int  opCountAtDone = 0;
    bit  fin = 0;
    bit  aborted = 0;
    bit  hs;
    bit  pending;
    logic [4:0] curSel = '0;

    buildModel(e);
    actOps.delete();

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, "_busy_on_accept"}, busy, 1);

    while (wordsSent < NW && cyc < 2000) begin
      e_valid = abuse ? ($urandom_range(0, 2) != 0) : 1'b1;
      e_word  = e[wordsSent*DW +: DW];
      start   = abuse ? ($urandom_range(0, 3) == 0) : 1'b0;
      hs      = e_valid && e_ready;
      @(negedge clk);
      if (hs) wordsSent++;
      cyc++;
    end
    e_valid = 1'b0;
    start   = 1'b0;
    checkOutput({name, "_words_loaded"}, wordsSent, NW);
    checkOutput({name, "_eready_off"}, e_ready, 0);

    cyc = 0;
    while (!fin && cyc < 30000) begin
      pending = (cnt > 0);
      mp_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) mp_done = 1'b1;
      end
      if (mp_start) begin
        if (pending) extraStart++;
        curSel = {mp_a_sel, mp_b_sel, mp_dst_sel};
        actOps.push_back(curSel);
        cnt = $urandom_range(dMin, dMax);
        if (abuse && $urandom_range(0, 1) == 1) mp_done = 1'b1;
      end else if (pending) begin
        if ({mp_a_sel, mp_b_sel, mp_dst_sel} !== curSel) selBad++;
      end
      if (state == 4'd4) scanCycles++;
      if (abuse && (state == 4'd4 || state == 4'd7) && $urandom_range(0, 3) == 0) mp_done = 1'b1;
      start = (abuse && state != 4'd0) ? ($urandom_range(0, 4) == 0) : 1'b0;
      if (!busy) busyDrop++;
      if (done) begin
        doneSeen++;
        opCountAtDone = op_count;
        fin = 1;
      end
      if (abortInSqr && state == 4'd5) begin
        reset   = 1'b0;
        aborted = 1;
        fin     = 1;
      end
      @(negedge clk);
      cyc++;
    end
    mp_done = 1'b0;
    start   = 1'b0;

    if (abortInSqr) begin
      checkOutput({name, "_reached_sqr"}, aborted, 1);
      checkOutput({name, "_rst_state"}, state, 0);
      checkOutput({name, "_rst_busy"}, busy, 0);
      checkOutput({name, "_rst_mp_start"}, mp_start, 0);
      checkOutput({name, "_rst_op_count"}, op_count, 0);
      checkOutput({name, "_rst_e_ready"}, e_ready, 0);
      reset = 1'b1;
      return;
    end

    checkOutput({name, "_done_seen"}, doneSeen, 1);
    checkOutput({name, "_op_count"}, opCountAtDone, expOpCount);
    checkOutput({name, "_num_ops"}, actOps.size(), expOps.size());
    for (int i = 0; i < expOps.size() && i < actOps.size(); i++)
      if (actOps[i] !== expOps[i]) opBad++;
    checkOutput({name, "_op_seq_bad"}, opBad, 0);
    checkOutput({name, "_scan_cycles"}, scanCycles, expScan);
    checkOutput({name, "_sel_stable_bad"}, selBad, 0);
    checkOutput({name, "_extra_mp_start"}, extraStart, 0);
    checkOutput({name, "_busy_drop"}, busyDrop, 0);
    checkOutput({name, "_idle_after"}, state, 0);
    checkOutput({name, "_busy_after"}, busy, 0);
    @(negedge clk);
    checkOutput({name, "_single_done"}, done, 0);
  endtask

  initial begin
    logic [KB-1:0] eVal;
    reset   = 1'b0;
    start   = 1'b0;
    e_valid = 1'b0;
    e_word  = '0;
    mp_done = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", state, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_e_ready", e_ready, 0);
    checkOutput("reset_op_count", op_count, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_mp_start", mp_start, 0);
    reset = 1'b1;

    eVal = '0;
    eVal[3:0] = 4'hB;
    applyStimulus(eVal, 3, 3, 0, 1, "abort_sqr");
    applyStimulus(eVal, 3, 3, 0, 0, "e_0xB");

    eVal = '0;
    applyStimulus(eVal, 2, 2, 0, 0, "e_zero");

    eVal = '0;
    eVal[0] = 1'b1;
    applyStimulus(eVal, 1, 4, 0, 0, "e_one");

    eVal = '0;
    eVal[KB-1] = 1'b1;
    applyStimulus(eVal, 1, 1, 0, 0, "e_top");

    eVal = '0;
    eVal[0] = 1'b1;
    applyStimulus(eVal, 50, 50, 1, 0, "holdoff50");

    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < NW; w++) eVal[w*DW +: DW] = {$urandom, $urandom};
      applyStimulus(eVal, 1, 3, 1, 0, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
